// File: rtl/mealy_pattern_tx_if.sv
// Handshake and serial-stream bundle for the "11" pattern transmitter.
// The master drives start/data/len and observes the framed stream; the slave is the transmitter.
interface mealy_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] len;
    logic             w;
    logic             valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pair_count;

    modport master (
        output start, data, len,
        input  w, valid, busy, done, pair_count
    );

    modport slave (
        input  start, data, len,
        output w, valid, busy, done, pair_count
    );
endinterface

// File: rtl/mealy_pattern_tx.sv
// Serial MSB-first pattern transmitter feeding the "11" sequence detectors.
// Frames the stream with valid/busy/done and counts adjacent "11" pairs sent in the frame.
module mealy_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    mealy_pattern_tx_if.slave  bus,
    output logic               fsm_state
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] pair_r;
    logic             w_r;
    logic             valid_r;
    logic             busy_r;
    logic             done_r;

    // A zero or oversized length means "send the whole word".
    assign len_eff = (bus.len == '0 || bus.len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.len;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            rem     <= '0;
            pair_r  <= '0;
            w_r     <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    w_r     <= 1'b0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    if (bus.start) begin
                        w_r     <= bus.data[WIDTH-1];
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                        shreg   <= {bus.data[WIDTH-2:0], 1'b0};
                        rem     <= len_eff - CNT_W'(1);
                        pair_r  <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (rem != '0) begin
                        w_r   <= shreg[WIDTH-1];
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        rem   <= rem - CNT_W'(1);
                        // Pair formed by the bit on the wire now and the one about to go out.
                        if (w_r && shreg[WIDTH-1]) begin
                            pair_r <= pair_r + CNT_W'(1);
                        end
                    end else begin
                        w_r     <= 1'b0;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.w          = w_r;
    assign bus.valid      = valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.pair_count = pair_r;
    assign fsm_state      = (state == SEND);
endmodule
